// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing the register bank's single write port.
// An accepted request is registered and presented as a one-hot register enable
// plus a broadcast data word, one cycle after the grant.
// Optional feature: define WBARB_PERF_EN to build the saturating arbitration-loss
// counter on perf_lost. Without it, perf_lost is tied to zero and perf_clr is unused.

module wb_port_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 3,
    parameter int unsigned DW   = 32
) (
    input  logic                clk,
    input  logic                r,
    input  logic                hold,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [(1<<AW)-1:0]  wr_en,
    output logic [DW-1:0]       wr_data,
    output logic                wr_pend_vld,
    output logic [AW-1:0]       wr_pend_addr,
    input  logic                perf_clr,
    output logic [15:0]         perf_lost
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW   = 16;

    // Requester index base+k, wrapped modulo NREQ (k is always < NREQ).
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                               input int unsigned   k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Priority search starting at rr_ptr; only valid bits, hold and rr_ptr matter.
    always_comb begin
        grant_idx = '0;
        accept    = 1'b0;
        if (!hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!accept && req_valid[wrap_idx(rr_ptr, k)]) begin
                    accept    = 1'b1;
                    grant_idx = wrap_idx(rr_ptr, k);
                end
            end
        end
    end

    // One-hot grant toward the requesters.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    // Select the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Round-robin pointer: moves just past the winner on each acceptance.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= wrap_idx(grant_idx, 1);
        end
    end

    // Write-port register: single-cycle enable pulse, data and address held between writes.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            wr_en        <= '0;
            wr_data      <= '0;
            wr_pend_addr <= '0;
            wr_pend_vld  <= 1'b0;
        end else begin
            wr_pend_vld <= accept;
            if (accept) begin
                wr_en        <= NREG'(1) << sel_addr;
                wr_data      <= sel_data;
                wr_pend_addr <= sel_addr;
            end else begin
                wr_en        <= '0;
            end
        end
    end

`ifdef WBARB_PERF_EN
    logic          contention;
    logic [CW-1:0] lost_cnt;

    // Two or more requesters valid while the port is open means somebody lost.
    always_comb begin
        contention = !hold && (|(req_valid & (req_valid - NREQ'(1))));
    end

    // Saturating loss counter; clear wins over increment.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            lost_cnt <= '0;
        end else if (perf_clr) begin
            lost_cnt <= '0;
        end else if (contention && (lost_cnt != {CW{1'b1}})) begin
            lost_cnt <= lost_cnt + CW'(1);
        end
    end

    assign perf_lost = lost_cnt;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign perf_lost       = 16'h0000;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (NREQ=3, AW=3, DW=32).
// Inputs change 1ns after the rising edge; outputs are sampled there too.

module tb_wb_port_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 32;

    logic                clk;
    logic                r;
    logic                hold;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [7:0]          wr_en;
    logic [DW-1:0]       wr_data;
    logic                wr_pend_vld;
    logic [AW-1:0]       wr_pend_addr;
    logic                perf_clr;
    logic [15:0]         perf_lost;

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .r            (r),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_pend_vld  (wr_pend_vld),
        .wr_pend_addr (wr_pend_addr),
        .perf_clr     (perf_clr),
        .perf_lost    (perf_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; leaves time at posedge+3.
    task automatic do_reset();
        r = 1'b0;
        #2;
        r = 1'b1;
    endtask

    task automatic test_reset();
        r = 1'b0;
        hold = 1'b0;
        perf_clr = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        #12;
        n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL reset_wr_en: got %b want %b", wr_en, 8'h00); end
        n_vec++; if (wr_data !== 32'h0) begin n_err++; $display("FAIL reset_wr_data: got %h want %h", wr_data, 32'h0); end
        n_vec++; if (wr_pend_vld !== 1'b0) begin n_err++; $display("FAIL reset_pend_vld: got %b want 0", wr_pend_vld); end
        n_vec++; if (wr_pend_addr !== 3'd0) begin n_err++; $display("FAIL reset_pend_addr: got %0d want 0", wr_pend_addr); end
        n_vec++; if (perf_lost !== 16'h0) begin n_err++; $display("FAIL reset_perf: got %h want 0", perf_lost); end
        r = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_write();
        set_req(0, 3'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_grant: got %b want 001", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        n_vec++; if (wr_en !== 8'b0010_0000) begin n_err++; $display("FAIL single_wr_en: got %b want 00100000", wr_en); end
        n_vec++; if (wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
        n_vec++; if (wr_pend_addr !== 3'd5) begin n_err++; $display("FAIL single_pend_addr: got %0d want 5", wr_pend_addr); end
        n_vec++; if (wr_pend_vld !== 1'b1) begin n_err++; $display("FAIL single_pend_vld: got %b want 1", wr_pend_vld); end
        #1;
        n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL single_idle_ready: got %b want 000", req_ready); end
        next_cycle();
        n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL single_pulse_end: got %b want 0", wr_en); end
        n_vec++; if (wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data_hold: got %h want deadbeef", wr_data); end
        n_vec++; if (wr_pend_vld !== 1'b0) begin n_err++; $display("FAIL single_vld_end: got %b want 0", wr_pend_vld); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_rdy [6];
        logic [7:0] exp_en  [6];
        logic [31:0] exp_dat [6];
        exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_en  = '{8'h02, 8'h04, 8'h08, 8'h02, 8'h04, 8'h08};
        exp_dat = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h101, 32'h102};
        do_reset();
        set_req(0, 3'd1, 32'h100);
        set_req(1, 3'd2, 32'h101);
        set_req(2, 3'd3, 32'h102);
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            n_vec++; if (req_ready !== exp_rdy[k]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy[k]); end
            next_cycle();
            if (k == 5) req_valid = 3'b000;
            n_vec++; if (wr_en !== exp_en[k]) begin n_err++; $display("FAIL rr_wr_en[%0d]: got %b want %b", k, wr_en, exp_en[k]); end
            n_vec++; if (wr_data !== exp_dat[k]) begin n_err++; $display("FAIL rr_wr_data[%0d]: got %h want %h", k, wr_data, exp_dat[k]); end
        end
`ifdef WBARB_PERF_EN
        n_vec++; if (perf_lost !== 16'd6) begin n_err++; $display("FAIL rr_perf: got %0d want 6", perf_lost); end
`else
        n_vec++; if (perf_lost !== 16'd0) begin n_err++; $display("FAIL rr_perf_off: got %0d want 0", perf_lost); end
`endif
    endtask

    task automatic test_hold();
        do_reset();
        req_valid = 3'b111;
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL hold_pre_grant: got %b want 001", req_ready); end
        next_cycle();
        hold = 1'b1;
        n_vec++; if (wr_en !== 8'h02) begin n_err++; $display("FAIL hold_inflight: got %b want 00000010", wr_en); end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 000", k, req_ready); end
            next_cycle();
            n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL hold_wr_en[%0d]: got %b want 0", k, wr_en); end
        end
        hold = 1'b0;
        #1;
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL hold_release_grant: got %b want 010", req_ready); end
        req_valid = 3'b000;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 3'd2, 32'd1);
        set_req(1, 3'd2, 32'd2);
        req_valid = 3'b001;
        #1;
        n_vec++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL b2b_grant0: got %b want 001", req_ready); end
        next_cycle();
        req_valid = 3'b010;
        n_vec++; if (wr_en !== 8'b0000_0100) begin n_err++; $display("FAIL b2b_en0: got %b want 00000100", wr_en); end
        n_vec++; if (wr_data !== 32'd1) begin n_err++; $display("FAIL b2b_data0: got %h want 1", wr_data); end
        #1;
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL b2b_grant1: got %b want 010", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        n_vec++; if (wr_en !== 8'b0000_0100) begin n_err++; $display("FAIL b2b_en1: got %b want 00000100", wr_en); end
        n_vec++; if (wr_data !== 32'd2) begin n_err++; $display("FAIL b2b_data1: got %h want 2", wr_data); end
        next_cycle();
        n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL b2b_end: got %b want 0", wr_en); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(0, 3'd3, 32'hCAFE0000);
        set_req(1, 3'd6, 32'hCAFE0001);
        req_valid = 3'b001;
        next_cycle();
        req_valid = 3'b000;
        n_vec++; if (wr_en !== 8'h08) begin n_err++; $display("FAIL arst_pre_en: got %b want 00001000", wr_en); end
        #1;
        r = 1'b0;
        #1;
        n_vec++; if (wr_en !== 8'h00) begin n_err++; $display("FAIL arst_wr_en: got %b want 0", wr_en); end
        n_vec++; if (wr_data !== 32'h0) begin n_err++; $display("FAIL arst_wr_data: got %h want 0", wr_data); end
        n_vec++; if (wr_pend_vld !== 1'b0) begin n_err++; $display("FAIL arst_vld: got %b want 0", wr_pend_vld); end
        req_valid = 3'b110;
        r = 1'b1;
        #1;
        n_vec++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL arst_first_grant: got %b want 010", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        n_vec++; if (wr_en !== 8'h40) begin n_err++; $display("FAIL arst_post_en: got %b want 01000000", wr_en); end
        next_cycle();
    endtask

    task automatic test_perf_counter();
        do_reset();
        set_req(0, 3'd0, 32'h0);
        set_req(1, 3'd1, 32'h1);
        set_req(2, 3'd2, 32'h2);
`ifdef WBARB_PERF_EN
        req_valid = 3'b011;
        for (int k = 0; k < 65534; k++) next_cycle();
        n_vec++; if (perf_lost !== 16'hFFFE) begin n_err++; $display("FAIL perf_preload: got %h want fffe", perf_lost); end
        for (int k = 0; k < 3; k++) next_cycle();
        n_vec++; if (perf_lost !== 16'hFFFF) begin n_err++; $display("FAIL perf_saturate: got %h want ffff", perf_lost); end
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        n_vec++; if (perf_lost !== 16'h0000) begin n_err++; $display("FAIL perf_clear: got %h want 0", perf_lost); end
        next_cycle();
        n_vec++; if (perf_lost !== 16'h0001) begin n_err++; $display("FAIL perf_resume: got %h want 1", perf_lost); end
        hold = 1'b1;
        next_cycle();
        hold = 1'b0;
        n_vec++; if (perf_lost !== 16'h0001) begin n_err++; $display("FAIL perf_hold: got %h want 1", perf_lost); end
        req_valid = 3'b100;
        next_cycle();
        n_vec++; if (perf_lost !== 16'h0001) begin n_err++; $display("FAIL perf_single: got %h want 1", perf_lost); end
`else
        req_valid = 3'b111;
        perf_clr = 1'b1;
        for (int k = 0; k < 4; k++) next_cycle();
        perf_clr = 1'b0;
        next_cycle();
        n_vec++; if (perf_lost !== 16'h0000) begin n_err++; $display("FAIL perf_disabled: got %h want 0", perf_lost); end
`endif
        req_valid = 3'b000;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_perf_counter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
